// File: rtl/linear_layer_bwd.sv
// Backward pass of a fixed-point linear layer: grad_in = (W^T * grad_out) >>> FRAC, one weight row per cycle.
// Define LINEAR_LAYER_BWD_SAT_EN to saturate each lane to WIDTH bits instead of wrapping.
module linear_layer_bwd #(
  parameter int WIDTH = 16,
  parameter int NIN   = 4,
  parameter int NOUT  = 4,
  parameter int FRAC  = 8,
  parameter logic [WIDTH*NIN*NOUT-1:0] WEIGHTS_MATRIX_FLAT = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [WIDTH-1:0] grad_out [0:NOUT-1],
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [WIDTH-1:0] grad_in [0:NIN-1],
  output logic                    out_valid,
  input  logic                    out_ready
);
  localparam int PW = 2 * WIDTH;
  localparam int AW = 2 * WIDTH + $clog2(NOUT) + 1;
  localparam int RW = (NOUT > 1) ? $clog2(NOUT) : 1;
  localparam logic [RW-1:0] LAST_ROW = RW'(NOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                  state_q, state_d;
  logic [RW-1:0]           row_q, row_d;
  logic signed [WIDTH-1:0] gbuf_q [NOUT];
  logic signed [WIDTH-1:0] gbuf_d [NOUT];
  logic signed [AW-1:0]    acc_q [NIN];
  logic signed [AW-1:0]    acc_d [NIN];
  logic signed [AW-1:0]    acc_sum [NIN];
  logic signed [WIDTH-1:0] gin_q [NIN];
  logic signed [WIDTH-1:0] gin_d [NIN];
  logic signed [WIDTH-1:0] gin_red [NIN];
  logic signed [WIDTH-1:0] w_arr [NOUT][NIN];
  logic signed [WIDTH-1:0] g_sel;

  // Unpack the layer-layout weight vector: row 0 and element 0 sit at the most significant end.
  generate
    for (genvar ri = 0; ri < NOUT; ri++) begin : g_row
      for (genvar ci = 0; ci < NIN; ci++) begin : g_col
        assign w_arr[ri][ci] = WEIGHTS_MATRIX_FLAT[(NIN*(NOUT-ri)-1-ci)*WIDTH +: WIDTH];
      end
    end
  endgenerate

  assign g_sel = gbuf_q[row_q];

  generate
    for (genvar gi = 0; gi < NIN; gi++) begin : g_lane
      logic signed [PW-1:0]    prod;
      logic signed [WIDTH-1:0] red;

      assign prod        = PW'(w_arr[row_q][gi]) * PW'(g_sel);
      assign acc_sum[gi] = acc_q[gi] + AW'(prod);

`ifdef LINEAR_LAYER_BWD_SAT_EN
      localparam logic signed [AW-1:0] SAT_MAX = {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
      localparam logic signed [AW-1:0] SAT_MIN = {{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
      logic signed [AW-1:0] shifted;

      assign shifted = acc_sum[gi] >>> FRAC;
      always_comb begin
        if (shifted > SAT_MAX) begin
          red = SAT_MAX[WIDTH-1:0];
        end else if (shifted < SAT_MIN) begin
          red = SAT_MIN[WIDTH-1:0];
        end else begin
          red = shifted[WIDTH-1:0];
        end
      end
`else
      assign red = WIDTH'(acc_sum[gi] >>> FRAC);
`endif

      assign gin_red[gi] = red;
      assign grad_in[gi] = gin_q[gi];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    for (int i = 0; i < NOUT; i++) gbuf_d[i] = gbuf_q[i];
    for (int j = 0; j < NIN; j++) begin
      acc_d[j] = acc_q[j];
      gin_d[j] = gin_q[j];
    end
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          for (int i = 0; i < NOUT; i++) gbuf_d[i] = grad_out[i];
          for (int j = 0; j < NIN; j++) acc_d[j] = '0;
          row_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        for (int j = 0; j < NIN; j++) acc_d[j] = acc_sum[j];
        row_d = row_q + RW'(1);
        // The last row's products are folded straight into the result registers.
        if (row_q == LAST_ROW) begin
          for (int j = 0; j < NIN; j++) gin_d[j] = gin_red[j];
          row_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      for (int i = 0; i < NOUT; i++) gbuf_q[i] <= '0;
      for (int j = 0; j < NIN; j++) begin
        acc_q[j] <= '0;
        gin_q[j] <= '0;
      end
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      for (int i = 0; i < NOUT; i++) gbuf_q[i] <= gbuf_d[i];
      for (int j = 0; j < NIN; j++) begin
        acc_q[j] <= acc_d[j];
        gin_q[j] <= gin_d[j];
      end
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
endmodule

// File: tb/tb_linear_layer_bwd.sv
// Scoreboard bench for linear_layer_bwd: identity, transpose and all-0x7FFF weight instances share clk/rst_n.
module tb_linear_layer_bwd;
  localparam int W = 16, NIN = 4, NOUT = 4, FRAC = 8;
  localparam logic [255:0] W_ID  = 256'h0100_0000_0000_0000_0000_0100_0000_0000_0000_0000_0100_0000_0000_0000_0000_0100;
  localparam logic [255:0] W_TR  = {64'h0100_0200_0000_0000, 192'h0};
  localparam logic [255:0] W_SAT = {16{16'h7FFF}};
`ifdef LINEAR_LAYER_BWD_SAT_EN
  localparam logic [63:0] SAT_EXP = 64'h7FFF_7FFF_7FFF_7FFF;
`else
  localparam logic [63:0] SAT_EXP = 64'hFC00_FC00_FC00_FC00;
`endif

  logic clk, rst_n;
  logic signed [W-1:0] g_id [0:NOUT-1];
  logic signed [W-1:0] g_tr [0:NOUT-1];
  logic signed [W-1:0] g_sat [0:NOUT-1];
  logic signed [W-1:0] gi_id [0:NIN-1];
  logic signed [W-1:0] gi_tr [0:NIN-1];
  logic signed [W-1:0] gi_sat [0:NIN-1];
  logic iv_id, ir_id, ov_id, or_id;
  logic iv_tr, ir_tr, ov_tr, or_tr;
  logic iv_sat, ir_sat, ov_sat, or_sat;

  int tests = 0, fails = 0, cyc = 0, last_rise = -1;
  bit b2b_on = 0;
  logic [63:0] exp_id[$], exp_tr[$], exp_sat[$];
  int acc_cyc[$];

  linear_layer_bwd #(.WIDTH(W), .NIN(NIN), .NOUT(NOUT), .FRAC(FRAC), .WEIGHTS_MATRIX_FLAT(W_ID)) u_id (
    .clk(clk), .rst_n(rst_n), .grad_out(g_id), .in_valid(iv_id), .in_ready(ir_id),
    .grad_in(gi_id), .out_valid(ov_id), .out_ready(or_id));
  linear_layer_bwd #(.WIDTH(W), .NIN(NIN), .NOUT(NOUT), .FRAC(FRAC), .WEIGHTS_MATRIX_FLAT(W_TR)) u_tr (
    .clk(clk), .rst_n(rst_n), .grad_out(g_tr), .in_valid(iv_tr), .in_ready(ir_tr),
    .grad_in(gi_tr), .out_valid(ov_tr), .out_ready(or_tr));
  linear_layer_bwd #(.WIDTH(W), .NIN(NIN), .NOUT(NOUT), .FRAC(FRAC), .WEIGHTS_MATRIX_FLAT(W_SAT)) u_sat (
    .clk(clk), .rst_n(rst_n), .grad_out(g_sat), .in_valid(iv_sat), .in_ready(ir_sat),
    .grad_in(gi_sat), .out_valid(ov_sat), .out_ready(or_sat));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, fails=%0d", fails);
    $fatal(1);
  end

  function automatic logic [63:0] pk(input logic signed [W-1:0] a [0:NIN-1]);
    return {a[0], a[1], a[2], a[3]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end else begin
      $display("[TB] %s ok: %h", name, act);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out, got no event required one", name);
  endtask

  // Output monitor: pops expected vectors on each handshake and times out_valid rises on u_id.
  initial begin
    logic prev_ov;
    logic [63:0] e;
    prev_ov = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_ov = 1'b0;
      end else begin
        if (iv_id && ir_id) acc_cyc.push_back(cyc);
        if (ov_id && !prev_ov) begin
          if (acc_cyc.size() == 0) timeout("id_latency_no_accept");
          else check("id_latency", 64'(cyc - acc_cyc.pop_front()), 64'(NOUT + 1));
          if (b2b_on && last_rise >= 0) check("b2b_spacing", 64'(cyc - last_rise), 64'(NOUT + 2));
          if (b2b_on) last_rise = cyc;
        end
        prev_ov = ov_id;
        if (ov_id && or_id) begin
          if (exp_id.size() == 0) begin
            tests++; fails++;
            $display("FAIL id_unexpected: got %h required no output", pk(gi_id));
          end else begin
            e = exp_id.pop_front();
            check("id_data", pk(gi_id), e);
          end
        end
        if (ov_tr && or_tr) begin
          if (exp_tr.size() == 0) begin
            tests++; fails++;
            $display("FAIL tr_unexpected: got %h required no output", pk(gi_tr));
          end else begin
            e = exp_tr.pop_front();
            check("tr_data", pk(gi_tr), e);
          end
        end
        if (ov_sat && or_sat) begin
          if (exp_sat.size() == 0) begin
            tests++; fails++;
            $display("FAIL sat_unexpected: got %h required no output", pk(gi_sat));
          end else begin
            e = exp_sat.pop_front();
            check("sat_data", pk(gi_sat), e);
          end
        end
      end
    end
  end

  task automatic send(input int inst, input logic [63:0] v, input logic [63:0] e);
    int n;
    n = 0;
    while (!(inst == 0 ? ir_id : (inst == 1 ? ir_tr : ir_sat)) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) timeout("send_wait_ready");
    for (int i = 0; i < NOUT; i++) begin
      case (inst)
        0:       g_id[i]  = v[63-16*i -: 16];
        1:       g_tr[i]  = v[63-16*i -: 16];
        default: g_sat[i] = v[63-16*i -: 16];
      endcase
    end
    case (inst)
      0:       begin iv_id  = 1'b1; exp_id.push_back(e);  end
      1:       begin iv_tr  = 1'b1; exp_tr.push_back(e);  end
      default: begin iv_sat = 1'b1; exp_sat.push_back(e); end
    endcase
    @(posedge clk); #1;
    iv_id = 1'b0; iv_tr = 1'b0; iv_sat = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_id.size() + exp_tr.size() + exp_sat.size()) != 0 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) timeout("drain");
  endtask

  initial begin
    logic [63:0] b2b_v [3];
    int n;
    b2b_v[0] = 64'h0001_0002_0003_0004;
    b2b_v[1] = 64'hFFFF_8000_7FFF_0040;
    b2b_v[2] = 64'h1234_5678_9ABC_DEF0;
    rst_n = 1'b0;
    iv_id = 0; iv_tr = 0; iv_sat = 0;
    or_id = 1; or_tr = 1; or_sat = 1;
    for (int i = 0; i < NOUT; i++) begin g_id[i] = '0; g_tr[i] = '0; g_sat[i] = '0; end
    #12;
    check("rst_in_ready_id", ir_id, 1);
    check("rst_out_valid_id", ov_id, 0);
    check("rst_grad_in_id", pk(gi_id), 0);
    check("rst_in_ready_tr", ir_tr, 1);
    check("rst_out_valid_sat", ov_sat, 0);
    check("rst_grad_in_sat", pk(gi_sat), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    send(0, 64'h0100_0200_FF00_0000, 64'h0100_0200_FF00_0000);
    send(0, 64'h0080_FE00_7FFF_1234, 64'h0080_FE00_7FFF_1234);
    send(1, 64'h0100_0000_0000_0000, 64'h0100_0200_0000_0000);
    send(1, 64'h0300_1111_1111_1111, 64'h0300_0600_0000_0000);
    send(1, 64'hFF00_0000_0000_0000, 64'hFF00_FE00_0000_0000);
    send(2, 64'h7FFF_7FFF_7FFF_7FFF, SAT_EXP);
    drain();

    // Backpressure on the transpose instance while in_valid toggles and grad_out changes.
    or_tr = 1'b0;
    send(1, 64'h0100_0000_0000_0000, 64'h0100_0200_0000_0000);
    n = 0;
    while (!ov_tr && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) timeout("bp_wait_done");
    for (int k = 0; k < 10; k++) begin
      iv_tr = k[0];
      g_tr[0] = 16'(k * 16'h0111);
      check("bp_hold_data", pk(gi_tr), 64'h0100_0200_0000_0000);
      check("bp_in_ready", ir_tr, 0);
      check("bp_out_valid", ov_tr, 1);
      @(posedge clk); #1;
    end
    iv_tr = 1'b0;
    or_tr = 1'b1;
    @(posedge clk); #1;
    check("bp_release_in_ready", ir_tr, 1);
    check("bp_release_out_valid", ov_tr, 0);
    drain();

    // Reset while u_id is processing row 2.
    send(0, 64'h0500_0000_0000_0000, 64'h0500_0000_0000_0000);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", ov_id, 0);
    check("midrst_in_ready", ir_id, 1);
    check("midrst_grad_in_id", pk(gi_id), 0);
    check("midrst_grad_in_tr", pk(gi_tr), 0);
    @(posedge clk); #1;
    exp_id.delete();
    acc_cyc.delete();
    rst_n = 1'b1;
    send(0, 64'h0300_FD00_0010_0000, 64'h0300_FD00_0010_0000);
    drain();

    // Back-to-back: in_valid stays high across three vectors.
    b2b_on = 1'b1;
    last_rise = -1;
    iv_id = 1'b1;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < NOUT; i++) g_id[i] = b2b_v[k][63-16*i -: 16];
      exp_id.push_back(b2b_v[k]);
      n = 0;
      while (!ir_id && n < 50) begin @(posedge clk); #1; n++; end
      if (n >= 50) timeout("b2b_wait_ready");
      @(posedge clk); #1;
    end
    iv_id = 1'b0;
    drain();
    repeat (3) @(posedge clk);
    #1;
    b2b_on = 1'b0;

    check("leftover_expected", 64'(exp_id.size() + exp_tr.size() + exp_sat.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/linear_layer_bwd.md
LINEAR_LAYER_BWD -- requirements
Module: linear_layer_bwd

Interface
REQ-001 SHALL have parameter WIDTH, default 16: bit-width of gradients and weights (signed two's complement).
REQ-002 SHALL have parameter NIN, default 4: length of the input-gradient vector (forward input size).
REQ-003 SHALL have parameter NOUT, default 4: length of the output-gradient vector (forward output size).
REQ-004 SHALL have parameter FRAC, default 8: fractional bits of the fixed-point format shared by weights and gradients.
REQ-005 SHALL have parameter WEIGHTS_MATRIX_FLAT, width WIDTH*NIN*NOUT, default all zero: the forward weight matrix in layer layout.
- Row r occupies bits [NIN*(NOUT-r)*WIDTH-1 -: NIN*WIDTH].
- Element j of a row occupies the slice at offset (NIN-1-j)*WIDTH within the row, so element 0 is most significant.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port grad_out, input, signed WIDTH x [0:NOUT-1]: upstream gradient vector.
REQ-009 SHALL have port in_valid, input, 1 bit: grad_out is valid.
REQ-010 SHALL have port in_ready, output, 1 bit: block can accept a vector.
REQ-011 SHALL have port grad_in, output, signed WIDTH x [0:NIN-1]: computed grad_in = W^T * grad_out.
REQ-012 SHALL have port out_valid, output, 1 bit: grad_in is valid.
REQ-013 SHALL have port out_ready, input, 1 bit: downstream accepts grad_in.

Function
REQ-014 SHALL compute grad_in[j] = (sum over r of W[r][j]*grad_out[r]) >>> FRAC, for j = 0..NIN-1.
REQ-015 SHALL implement three states.
- IDLE: in_ready=1.
- ACCUM: in_ready=0, out_valid=0.
- DONE: out_valid=1, in_ready=0.
REQ-016 SHALL, on an IDLE cycle with in_valid=1, register all of grad_out, clear all NIN accumulators, zero the row counter and enter ACCUM.
REQ-017 SHALL, in ACCUM, process exactly one row r per cycle, running NIN parallel MACs: acc[j] += W[r][j]*grad_out_reg[r].
REQ-018 SHALL, after row NOUT-1 is processed, enter DONE.
- grad_in becomes valid exactly NOUT+1 cycles after the accepting edge.
REQ-019 SHALL size each product at 2*WIDTH bits and each accumulator at 2*WIDTH+$clog2(NOUT)+1 bits, so accumulation never overflows.
REQ-020 SHALL form each grad_in[j] by arithmetic right shift of its accumulator by FRAC, then reduce to WIDTH bits per REQ-028.
REQ-021 SHALL hold grad_in and out_valid stable in DONE until out_ready=1, and ignore in_valid changes while in DONE or ACCUM.
REQ-022 SHALL, on a DONE cycle with out_ready=1, return to IDLE.
- The next vector can be accepted no earlier than the following cycle.
- Back-to-back throughput is one vector per NOUT+2 cycles.
REQ-023 SHALL keep grad_in at its last computed value after leaving DONE, until the next DONE.
REQ-024 SHALL have zero combinational paths from in_valid or out_ready to any output.

Reset
REQ-025 SHALL, while rst_n=0, immediately force the following, regardless of clk:
- state to IDLE;
- in_ready=1;
- out_valid=0;
- all grad_in lanes, accumulators, registered gradients and the row counter to 0.
REQ-026 SHALL abandon any in-progress ACCUM or unacknowledged DONE on reset, with no output after reset until a new vector is accepted.
REQ-027 SHALL deassert reset glitch-free; the first accept SHALL be possible on the first rising edge with rst_n=1.

Configuration
REQ-028 SHALL support macro LINEAR_LAYER_BWD_SAT_EN.
- When defined, each shifted accumulator saturates to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- When undefined, each shifted accumulator is truncated to its low WIDTH bits (two's-complement wrap).

Verification
REQ-029 SHALL cover the following directed scenarios.
- Identity case: WIDTH=16, FRAC=8, NIN=NOUT=4, W = identity (0x0100 on the diagonal); grad_out = {0x0100, 0x0200, -0x0100, 0}. Required: grad_in = {0x0100, 0x0200, 0xFF00, 0}, out_valid rising exactly 5 cycles after accept.
- Transpose case: W row 0 = {0x0100, 0x0200, 0, 0}, other rows zero; grad_out[0] = 0x0100, others 0. Required: grad_in = {0x0100, 0x0200, 0, 0}.
- Saturation case: all W = 0x7FFF, all grad_out = 0x7FFF. With LINEAR_LAYER_BWD_SAT_EN defined: every grad_in = 0x7FFF. Without it: every grad_in equals the low 16 bits of (4*0x7FFF*0x7FFF)>>>8.
- Backpressure: hold out_ready=0 for 10 cycles in DONE while toggling in_valid. Required: grad_in stable, in_ready=0, and return to IDLE on the cycle after out_ready=1.
- Reset mid-ACCUM: assert rst_n=0 at row 2. Required: immediate out_valid=0, in_ready=1, grad_in=0, and a fresh vector afterwards producing the correct result.
- Back-to-back: in_valid held high for 3 vectors with out_ready=1. Required: 3 correct outputs spaced NOUT+2 cycles apart.
